alu_rf_sequencer: RTL and testbench

Instruction-driven master for the 8-bit ALU + register-file datapath; it is the initiator side of the register file's read/write port and the ALU opcode/carry port.
Accepts one instruction at a time over a valid/ready handshake and drives the register-file read addresses, ALU opcode and c_in. It then captures alu_out, writes the result back to the register file and reports it on a result port.
Keeps carry/zero flags so chained multi-byte arithmetic is possible.

---
 rtl/alu_rf_sequencer_pkg.sv | 31 +++
 rtl/alu_rf_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_rf_sequencer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rf_sequencer_pkg.sv
// Shared encodings for the ALU/register-file instruction sequencer:
// ALU opcodes, instruction kinds and sequencer FSM states.
package alu_rf_sequencer_pkg;

   // ALU opcode encoding presented on alu_opcode
   typedef enum logic [2:0] {
      OP_ADD    = 3'd0,
      OP_SUB    = 3'd1,
      OP_SUB_A  = 3'd2,
      OP_OR     = 3'd3,
      OP_AND    = 3'd4,
      OP_NOT_AB = 3'd5,
      OP_XOR    = 3'd6,
      OP_XNOR   = 3'd7
   } alu_op_e;

   // Instruction kind carried on instr_kind
   typedef enum logic {
      KIND_ALU  = 1'b0,
      KIND_LOAD = 1'b1
   } instr_kind_e;

   // Sequencer states: one instruction walks IDLE -> READ -> EXEC -> WRITE
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_EXEC  = 2'd2,
      ST_WRITE = 2'd3
   } state_e;

endpackage

// File: rtl/alu_rf_sequencer.sv
// Instruction-driven master for the 8-bit ALU + register-file datapath.
// Accepts one instruction at a time, drives register-file read addresses and
// the ALU opcode/carry, captures the ALU result (or an immediate), writes it
// back and reports it on a registered result port. Carry/zero flags are kept
// so multi-byte arithmetic can be chained with use_carry.
module alu_rf_sequencer
   import alu_rf_sequencer_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic              instr_kind,
   input  logic [2:0]        instr_opcode,
   input  logic              instr_cin,
   input  logic              instr_use_carry,
   input  logic [ADDR_W-1:0] instr_rd,
   input  logic [ADDR_W-1:0] instr_rs1,
   input  logic [ADDR_W-1:0] instr_rs2,
   input  logic [DATA_W-1:0] instr_imm,
   output logic [ADDR_W-1:0] rf_read_addr_1,
   output logic [ADDR_W-1:0] rf_read_addr_2,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic              rf_write_enable,
   output logic [DATA_W-1:0] rf_data_in,
   output logic [2:0]        alu_opcode,
   output logic              alu_c_in,
   input  logic [DATA_W:0]   alu_out,
   output logic              res_valid,
   output logic [DATA_W:0]   res_data,
   output logic              carry_flag,
   output logic              zero_flag
);

   state_e              state;
   state_e              state_nxt;
   logic                accept;
   instr_kind_e         lat_kind;
   logic [ADDR_W-1:0]   lat_rd;
   logic [DATA_W-1:0]   lat_imm;
   logic [DATA_W:0]     result;

   assign accept = instr_valid && (state == ST_IDLE);

   // Write-back data always reflects the captured result; it only changes
   // in EXEC, so it is stable through WRITE and holds afterwards.
   assign rf_data_in = result[DATA_W-1:0];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and state-decoded outputs (ready, write strobe)
   always_comb begin
      state_nxt       = state;
      instr_ready     = 1'b0;
      rf_write_enable = 1'b0;
      case (state)
         ST_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            rf_write_enable = 1'b1;
            state_nxt       = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Latch the instruction on the accept edge; read addresses, opcode and
   // carry-in are registered here so they are valid throughout READ and EXEC
   // and hold their values while idle. The carry choice is resolved now, so
   // use_carry sees the flags of the previously completed instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_read_addr_1 <= '0;
         rf_read_addr_2 <= '0;
         alu_opcode     <= '0;
         alu_c_in       <= 1'b0;
         lat_kind       <= KIND_ALU;
         lat_rd         <= '0;
         lat_imm        <= '0;
      end else if (accept) begin
         rf_read_addr_1 <= instr_rs1;
         rf_read_addr_2 <= instr_rs2;
         alu_opcode     <= instr_opcode;
         alu_c_in       <= instr_use_carry ? carry_flag : instr_cin;
         lat_kind       <= instr_kind_e'(instr_kind);
         lat_rd         <= instr_rd;
         lat_imm        <= instr_imm;
      end
   end

   // Capture the ALU output (or zero-extended immediate) and the write
   // address at the end of EXEC, ready for the WRITE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result        <= '0;
         rf_write_addr <= '0;
      end else if (state == ST_EXEC) begin
         if (lat_kind == KIND_LOAD) begin
            result <= {1'b0, lat_imm};
         end else begin
            result <= alu_out;
         end
         rf_write_addr <= lat_rd;
      end
   end

   // Result report and flag update on the write edge; res_valid is a
   // one-cycle pulse in the cycle following WRITE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid  <= 1'b0;
         res_data   <= '0;
         carry_flag <= 1'b0;
         zero_flag  <= 1'b0;
      end else begin
         res_valid <= (state == ST_WRITE);
         if (state == ST_WRITE) begin
            res_data  <= result;
            zero_flag <= (result[DATA_W-1:0] == '0);
            if (lat_kind == KIND_ALU) begin
               carry_flag <= result[DATA_W];
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Self-checking bench for alu_rf_sequencer: a behavioural register file and
// ALU are wired to the sequencer, an architectural model predicts each
// result into a scoreboard queue, and each test task compares DUT outputs.
module tb_alu_rf_sequencer;

   logic       clk;
   logic       rst_n;
   logic       instr_valid;
   logic       instr_ready;
   logic       instr_kind;
   logic [2:0] instr_opcode;
   logic       instr_cin;
   logic       instr_use_carry;
   logic [2:0] instr_rd;
   logic [2:0] instr_rs1;
   logic [2:0] instr_rs2;
   logic [7:0] instr_imm;
   logic [2:0] rf_read_addr_1;
   logic [2:0] rf_read_addr_2;
   logic [2:0] rf_write_addr;
   logic       rf_write_enable;
   logic [7:0] rf_data_in;
   logic [2:0] alu_opcode;
   logic       alu_c_in;
   logic [8:0] alu_out;
   logic       res_valid;
   logic [8:0] res_data;
   logic       carry_flag;
   logic       zero_flag;

   alu_rf_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_kind(instr_kind), .instr_opcode(instr_opcode),
      .instr_cin(instr_cin), .instr_use_carry(instr_use_carry),
      .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
      .instr_imm(instr_imm),
      .rf_read_addr_1(rf_read_addr_1), .rf_read_addr_2(rf_read_addr_2),
      .rf_write_addr(rf_write_addr), .rf_write_enable(rf_write_enable),
      .rf_data_in(rf_data_in), .alu_opcode(alu_opcode), .alu_c_in(alu_c_in),
      .alu_out(alu_out), .res_valid(res_valid), .res_data(res_data),
      .carry_flag(carry_flag), .zero_flag(zero_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Behavioural ALU. not_ab is modelled as (~a & b); the tests do not use it.
   function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op, input logic ci);
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b} + {8'd0, ci};
         3'd1:    return {1'b0, a} + {1'b0, ~b} + {8'd0, ci};
         3'd2:    return {1'b0, b} + {1'b0, ~a} + {8'd0, ci};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a & b};
         3'd5:    return {1'b0, ~a & b};
         3'd6:    return {1'b0, a ^ b};
         default: return {1'b0, ~(a ^ b)};
      endcase
   endfunction

   // Behavioural register file (not reset; cleared by the bench at start)
   logic [7:0] rf [8];
   logic       rf_clear;
   always @(posedge clk) begin
      if (rf_clear) begin
         for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      end else if (rf_write_enable) begin
         rf[rf_write_addr] <= rf_data_in;
      end
   end
   always_comb alu_out = alu_fn(rf[rf_read_addr_1], rf[rf_read_addr_2], alu_opcode, alu_c_in);

   // Edge counter and negedge monitor of accepts and writes
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         acc_count = 0;
   int         wr_count = 0;
   int         acc_edges [$];
   int         last_acc_edge = 0;
   int         last_wr_edge = 0;
   logic [2:0] last_wr_addr = '0;
   logic [7:0] last_wr_data = '0;
   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready) begin
         acc_count     = acc_count + 1;
         last_acc_edge = cyc + 1;
         acc_edges.push_back(cyc + 1);
      end
      if (rf_write_enable) begin
         wr_count     = wr_count + 1;
         last_wr_edge = cyc + 1;
         last_wr_addr = rf_write_addr;
         last_wr_data = rf_data_in;
      end
   end

   // Architectural reference model and scoreboard
   typedef struct {
      logic [8:0] res;
      logic [2:0] rd;
      logic       c;
      logic       z;
   } exp_t;

   exp_t       sb [$];
   logic [7:0] ref_rf [8];
   logic       ref_c = 1'b0;
   logic       ref_z = 1'b0;

   function automatic exp_t predict(input logic kind, input logic [2:0] op, input logic cin,
                                    input logic uc, input logic [2:0] rd, input logic [2:0] rs1,
                                    input logic [2:0] rs2, input logic [7:0] imm);
      exp_t e;
      if (kind) e.res = {1'b0, imm};
      else      e.res = alu_fn(ref_rf[rs1], ref_rf[rs2], op, uc ? ref_c : cin);
      ref_rf[rd] = e.res[7:0];
      if (!kind) ref_c = e.res[8];
      ref_z = (e.res[7:0] == 8'h00);
      e.rd = rd;
      e.c  = ref_c;
      e.z  = ref_z;
      return e;
   endfunction

   task automatic drive_fields(input logic kind, input logic [2:0] op, input logic cin,
                               input logic uc, input logic [2:0] rd, input logic [2:0] rs1,
                               input logic [2:0] rs2, input logic [7:0] imm);
      instr_kind = kind; instr_opcode = op; instr_cin = cin; instr_use_carry = uc;
      instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
   endtask

   // Predict, push, offer and hold until accepted; returns just after the
   // accept edge (DUT in READ).
   task automatic send(input logic kind, input logic [2:0] op, input logic cin,
                       input logic uc, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [7:0] imm);
      int n;
      sb.push_back(predict(kind, op, cin, uc, rd, rs1, rs2, imm));
      @(posedge clk); #1;
      drive_fields(kind, op, cin, uc, rd, rs1, rs2, imm);
      instr_valid = 1'b1;
      n = 0;
      while (1) begin
         @(negedge clk);
         if (instr_ready) break;
         n++;
         if (n > 50) begin
            checks++; failures++;
            $display("FAIL accept_timeout: instr_ready=%0b required 1 within 50 cycles", instr_ready);
            break;
         end
      end
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   // Wait (bounded) for the res_valid pulse and return what was observed.
   task automatic get_result(output bit ok, output logic [8:0] d, output logic c, output logic z);
      ok = 1'b0; d = '0; c = 1'b0; z = 1'b0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (res_valid) begin
            ok = 1'b1; d = res_data; c = carry_flag; z = zero_flag;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; rf_clear = 1'b1; instr_valid = 1'b0;
      drive_fields(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
      for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if ({instr_ready, res_valid, rf_write_enable, carry_flag, zero_flag} !== 5'b10000) begin
         failures++;
         $display("FAIL reset_ctrl: ready/rv/we/c/z=%b required 10000",
                  {instr_ready, res_valid, rf_write_enable, carry_flag, zero_flag});
      end
      checks++;
      if ({rf_read_addr_1, rf_read_addr_2, rf_write_addr, rf_data_in, alu_opcode, alu_c_in, res_data} !== '0) begin
         failures++;
         $display("FAIL reset_data: ra1=%0d ra2=%0d wa=%0d wd=%h op=%0d cin=%0b res=%h required all 0",
                  rf_read_addr_1, rf_read_addr_2, rf_write_addr, rf_data_in, alu_opcode, alu_c_in, res_data);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; rf_clear = 1'b0;
   endtask

   task automatic test_load;
      bit ok; logic [8:0] d; logic c, z; exp_t e;
      logic [7:0] imms [2] = '{8'h55, 8'hAA};
      for (int k = 0; k < 2; k++) begin
         send(1'b1, 3'd0, 1'b0, 1'b0, 3'(k + 1), 3'd0, 3'd0, imms[k]);
         get_result(ok, d, c, z);
         e = sb.pop_front();
         checks++;
         if (!ok || d !== e.res || z !== e.z) begin
            failures++;
            $display("FAIL load_%0d: ok=%0b res=%h z=%0b required res=%h z=%0b", k, ok, d, z, e.res, e.z);
         end
         checks++;
         if (last_wr_addr !== e.rd || last_wr_data !== e.res[7:0]) begin
            failures++;
            $display("FAIL load_wr_%0d: addr=%0d data=%h required addr=%0d data=%h",
                     k, last_wr_addr, last_wr_data, e.rd, e.res[7:0]);
         end
      end
   endtask

   task automatic test_add;
      bit ok; logic [8:0] d; logic c, z; exp_t e;
      send(1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 3'd1, 3'd2, 8'h00);
      get_result(ok, d, c, z);
      e = sb.pop_front();
      checks++;
      if (!ok || d !== e.res || c !== e.c || z !== e.z) begin
         failures++;
         $display("FAIL add: ok=%0b res=%h c=%0b z=%0b required res=%h c=%0b z=%0b", ok, d, c, z, e.res, e.c, e.z);
      end
      checks++;
      if (last_wr_edge - last_acc_edge !== 3) begin
         failures++;
         $display("FAIL add_latency: write-accept edges=%0d required 3", last_wr_edge - last_acc_edge);
      end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0) begin
         failures++;
         $display("FAIL res_pulse: res_valid=%0b required 0 one cycle later", res_valid);
      end
   endtask

   task automatic test_carry_chain;
      bit ok; logic [8:0] d; logic c, z; exp_t e;
      send(1'b0, 3'd0, 1'b1, 1'b0, 3'd4, 3'd1, 3'd2, 8'h00);
      get_result(ok, d, c, z);
      e = sb.pop_front();
      checks++;
      if (!ok || d !== e.res || c !== e.c || z !== e.z || last_wr_data !== 8'h00) begin
         failures++;
         $display("FAIL add_cin: ok=%0b res=%h c=%0b z=%0b wd=%h required res=%h c=%0b z=%0b wd=00",
                  ok, d, c, z, last_wr_data, e.res, e.c, e.z);
      end
      // instr_cin=0 must be ignored: carry comes from carry_flag
      send(1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 3'd1, 3'd1, 8'h00);
      checks++;
      if (alu_c_in !== 1'b1 || rf_read_addr_1 !== 3'd1 || rf_read_addr_2 !== 3'd1) begin
         failures++;
         $display("FAIL use_carry_drive: cin=%0b ra1=%0d ra2=%0d required cin=1 ra1=1 ra2=1",
                  alu_c_in, rf_read_addr_1, rf_read_addr_2);
      end
      get_result(ok, d, c, z);
      e = sb.pop_front();
      checks++;
      if (!ok || d !== e.res || c !== e.c || z !== e.z) begin
         failures++;
         $display("FAIL use_carry: ok=%0b res=%h c=%0b z=%0b required res=%h c=%0b z=%0b", ok, d, c, z, e.res, e.c, e.z);
      end
   endtask

   task automatic test_logic;
      bit ok; logic [8:0] d; logic c, z; exp_t e;
      logic [2:0] ops [2] = '{3'd6, 3'd7};
      for (int k = 0; k < 2; k++) begin
         send(1'b0, ops[k], 1'b0, 1'b0, 3'(6 + k), 3'd1, 3'd2, 8'h00);
         get_result(ok, d, c, z);
         e = sb.pop_front();
         checks++;
         if (!ok || d !== e.res || c !== e.c || z !== e.z || last_wr_addr !== e.rd) begin
            failures++;
            $display("FAIL logic_op%0d: ok=%0b res=%h c=%0b z=%0b wa=%0d required res=%h c=%0b z=%0b wa=%0d",
                     ops[k], ok, d, c, z, last_wr_addr, e.res, e.c, e.z, e.rd);
         end
      end
   endtask

   task automatic test_back_to_back;
      int acc0, wr0, e0;
      logic [2:0] ops [3] = '{3'd3, 3'd4, 3'd0};
      logic [2:0] rds [3] = '{3'd0, 3'd3, 3'd4};
      logic       kds [3] = '{1'b0, 1'b0, 1'b1};
      acc0 = acc_count; wr0 = wr_count; e0 = acc_edges.size();
      fork
         begin
            int n;
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
               sb.push_back(predict(kds[k], ops[k], 1'b0, 1'b0, rds[k], 3'd1, 3'd2, 8'h3C));
               drive_fields(kds[k], ops[k], 1'b0, 1'b0, rds[k], 3'd1, 3'd2, 8'h3C);
               instr_valid = 1'b1;
               n = 0;
               while (1) begin
                  @(negedge clk);
                  if (instr_ready) break;
                  n++;
                  if (n > 50) begin
                     checks++; failures++;
                     $display("FAIL b2b_accept_timeout: instr_ready=%0b required 1", instr_ready);
                     break;
                  end
               end
               @(posedge clk); #1;
            end
            instr_valid = 1'b0;
         end
         begin
            bit ok; logic [8:0] d; logic c, z; exp_t e;
            for (int k = 0; k < 3; k++) begin
               get_result(ok, d, c, z);
               e = sb.pop_front();
               checks++;
               if (!ok || d !== e.res || c !== e.c || z !== e.z || last_wr_addr !== e.rd) begin
                  failures++;
                  $display("FAIL b2b_res_%0d: ok=%0b res=%h c=%0b z=%0b wa=%0d required res=%h c=%0b z=%0b wa=%0d",
                           k, ok, d, c, z, last_wr_addr, e.res, e.c, e.z, e.rd);
               end
            end
         end
      join
      repeat (6) @(negedge clk);
      checks++;
      if (acc_count - acc0 !== 3 || wr_count - wr0 !== 3) begin
         failures++;
         $display("FAIL b2b_counts: accepts=%0d writes=%0d required 3 and 3", acc_count - acc0, wr_count - wr0);
      end
      checks++;
      if (acc_edges.size() - e0 !== 3 ||
          acc_edges[e0 + 1] - acc_edges[e0] !== 4 || acc_edges[e0 + 2] - acc_edges[e0 + 1] !== 4) begin
         failures++;
         $display("FAIL b2b_spacing: accept edge gaps not 4 (count=%0d)", acc_edges.size() - e0);
      end
   endtask

   task automatic test_reset_mid;
      bit ok; logic [8:0] d; logic c, z; exp_t e; int wr0; int seen;
      send(1'b0, 3'd0, 1'b1, 1'b0, 3'd4, 3'd1, 3'd2, 8'h00);
      get_result(ok, d, c, z);
      e = sb.pop_front();
      checks++;
      if (!ok || c !== 1'b1 || z !== 1'b1 || d !== e.res) begin
         failures++;
         $display("FAIL pre_abort: ok=%0b res=%h c=%0b z=%0b required res=%h c=1 z=1", ok, d, c, z, e.res);
      end
      wr0 = wr_count;
      @(posedge clk); #1;
      drive_fields(1'b0, 3'd0, 1'b0, 1'b0, 3'd5, 3'd1, 3'd2, 8'h00);
      instr_valid = 1'b1;
      @(posedge clk); #1;          // accepted; now in READ
      instr_valid = 1'b0;
      @(posedge clk); #1;          // now in EXEC
      rst_n = 1'b0;
      #1;
      checks++;
      if ({instr_ready, rf_write_enable, res_valid, carry_flag, zero_flag} !== 5'b10000) begin
         failures++;
         $display("FAIL abort_state: ready/we/rv/c/z=%b required 10000",
                  {instr_ready, rf_write_enable, res_valid, carry_flag, zero_flag});
      end
      ref_c = 1'b0; ref_z = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (res_valid) seen++;
      end
      checks++;
      if (wr_count !== wr0 || seen !== 0) begin
         failures++;
         $display("FAIL abort_nowrite: writes=%0d res_pulses=%0d required 0 and 0", wr_count - wr0, seen);
      end
   endtask

   task automatic test_hazard;
      bit ok; logic [8:0] d; logic c, z; exp_t e;
      send(1'b0, 3'd0, 1'b0, 1'b0, 3'd6, 3'd6, 3'd6, 8'h00);
      get_result(ok, d, c, z);
      e = sb.pop_front();
      checks++;
      if (!ok || d !== e.res || c !== e.c || z !== e.z) begin
         failures++;
         $display("FAIL hazard_res: ok=%0b res=%h c=%0b z=%0b required res=%h c=%0b z=%0b", ok, d, c, z, e.res, e.c, e.z);
      end
      checks++;
      if (last_wr_addr !== 3'd6 || last_wr_data !== e.res[7:0]) begin
         failures++;
         $display("FAIL hazard_wr: addr=%0d data=%h required addr=6 data=%h", last_wr_addr, last_wr_data, e.res[7:0]);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_add();
      test_carry_chain();
      test_logic();
      test_back_to_back();
      test_reset_mid();
      test_hazard();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
